temporal_encoder_16: RTL and testbench
======================================

Name: temporal_encoder_16

Overview:
- Upstream stage of the 16-input bitonic sorter.
- Accepts 16 binary spike-time values through a valid/ready handshake.
- Drives 16 lines using 1->0 transition encoding: line i falls at gamma-cycle tick equal to its value, and the sorter orders those arrivals.
- After the compute window, a rest window returns all lines high before the next gamma cycle.

Parameters:
- N, 16, number of lines; the sorter requires 16.
- TW, 3, bits per spike time; compute window is 2^TW cycles.
- REST_CYC, 2, rest-window length in cycles; minimum 1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_data holds a valid 16-value vector
- in_ready  output  1  encoder can accept a vector
- in_data  input  N*TW  value for line i at in_data[TW*i +: TW]
- spike_out  output  N  encoded lines (idle high); feeds sorter raw_in
- gamma_start  output  1  one-cycle pulse on the first compute cycle
- gamma_done  output  1  one-cycle pulse on the last rest cycle
- busy  output  1  high in COMPUTE and REST

Behaviour:
- All outputs are registered.
- Reset values: spike_out=all ones, in_ready=1, busy=0, gamma_start=0, gamma_done=0, state=IDLE, tick=0, value registers=0.
- States: IDLE, COMPUTE, REST.
- IDLE:
  - in_ready=1, spike_out all ones.
  - On in_valid&&in_ready, capture in_data, clear tick, go to COMPUTE.
- COMPUTE:
  - Lasts exactly 2^TW cycles; tick = 0 .. 2^TW-1.
  - In the cycle with tick=c, spike_out[i]=0 iff val[i] <= c, so the transition is visible c+1 cycles after the handshake cycle.
  - Lines are monotonic: once low, they stay low until REST.
  - gamma_start=1 in the tick=0 cycle only.
  - After tick=2^TW-1, go to REST.
- REST:
  - spike_out all ones for REST_CYC cycles.
  - gamma_done=1 in the final REST cycle; then go to IDLE.
- in_ready=0 in COMPUTE and REST, so there is no back-to-back overlap.
  - Minimum handshake spacing is 2^TW+REST_CYC+1 cycles.
- in_data is sampled only on the handshake; later changes are ignored.
- Equal values fall on the same cycle; ordering among ties is left to the sorter.
- tick counter is TW+1 bits wide internally, with no wrap inside COMPUTE.
  - The REST counter is sized by $clog2(REST_CYC+1).
- rst mid-operation:
  - Next edge gives IDLE, spike_out all ones, captured values discarded.
  - No gamma_done pulse is emitted.
- in_valid held high while not ready: no effect; the vector is accepted on the cycle after the return to IDLE.

Optional Feature:
- Macro: TNN_NULL_SPIKE_EN.
- Defined: value all-ones (2^TW-1) is a null spike; that line stays high for the whole COMPUTE window.
- Not defined: all-ones falls at the last tick like any other value.

Decomposition:
- Package tnn_pkg contains:
  - localparams N_LINES=16 and TW_DEF=3
  - typedef spike_time_t (logic [TW-1:0])
  - typedef enum enc_state_t {IDLE, COMPUTE, REST}
- Sub-module gamma_timer owns the state machine, the tick/rest counters, and gamma_start, gamma_done and busy.
  - It is reused by the downstream time-capture stage.
- Per-line compare logic stays in a generate loop in temporal_encoder_16.

Test Plan:
- Reset then idle: rst held 3 cycles -> spike_out=16'hFFFF, in_ready=1, busy=0, no pulses.
- Distinct values: line i = i mod 8, handshake at cycle T:
  - At T+1, lines 0 and 8 go low.
  - At T+8, all lines are low.
  - At T+9, all lines are high.
  - gamma_done at T+10; in_ready=1 at T+11.
- Ties and monotonicity: all lines=3 -> all 16 fall together at T+4 and remain low through T+8.
- Mid-run reset: rst asserted at T+5 -> spike_out=16'hFFFF and state IDLE after that edge; no gamma_done pulse.
- Backpressure: in_valid held high with a second vector during COMPUTE -> it is accepted only when in_ready returns; the first vector's waveform is unaffected.
- Null spike:
  - Macro defined: line 5 = 7 stays high through COMPUTE.
  - Macro not defined: line 5 = 7 falls at T+8.

Source files
------------

// File: rtl/temporal_encoder_16_pkg.sv
// Shared types and defaults for the temporal encoder / gamma timer slice.
package tnn_pkg;

  localparam int unsigned N_LINES = 16;
  localparam int unsigned TW_DEF  = 3;

  typedef logic [TW_DEF-1:0] spike_time_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    REST    = 2'd2
  } enc_state_t;

endpackage

// File: rtl/temporal_encoder_16_if.sv
// Valid/ready input bus carrying one 16-value spike-time vector.
interface temporal_encoder_16_if
  import tnn_pkg::*;
#(
  parameter int unsigned N  = N_LINES,
  parameter int unsigned TW = TW_DEF
);

  logic            in_valid;
  logic            in_ready;
  logic [N*TW-1:0] in_data;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );

endinterface

// File: rtl/temporal_encoder_16_gamma_timer.sv
// Gamma-cycle sequencer: IDLE -> COMPUTE (2^TW ticks) -> REST (REST_CYC cycles).
// Exposes next-state/next-tick so a client can register outputs aligned to them.
module gamma_timer
  import tnn_pkg::*;
#(
  parameter int unsigned TW       = TW_DEF,
  parameter int unsigned REST_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output enc_state_t state_nxt,
  output logic [TW:0] tick_nxt,
  output logic       idle,
  output logic       gamma_start,
  output logic       gamma_done,
  output logic       busy
);

  localparam int unsigned RW        = $clog2(REST_CYC + 1);
  localparam logic [TW:0] TICK_LAST = (TW+1)'((1 << TW) - 1);
  localparam logic [RW-1:0] REST_LAST = RW'(REST_CYC - 1);

  enc_state_t    state;
  logic [TW:0]   tick;
  logic [RW-1:0] rest_cnt;
  logic [RW-1:0] rest_nxt;

  // Next-state and counter update.
  always_comb begin
    state_nxt = state;
    tick_nxt  = tick;
    rest_nxt  = rest_cnt;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = COMPUTE;
          tick_nxt  = '0;
        end
      end
      COMPUTE: begin
        if (tick == TICK_LAST) begin
          state_nxt = REST;
          rest_nxt  = '0;
        end else begin
          tick_nxt = tick + 1'b1;
        end
      end
      REST: begin
        if (rest_cnt == REST_LAST) begin
          state_nxt = IDLE;
          tick_nxt  = '0;
          rest_nxt  = '0;
        end else begin
          rest_nxt = rest_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        tick_nxt  = '0;
        rest_nxt  = '0;
      end
    endcase
  end

  // State, counters and status flags, all registered from next-state values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      tick        <= '0;
      rest_cnt    <= '0;
      idle        <= 1'b1;
      gamma_start <= 1'b0;
      gamma_done  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      tick        <= tick_nxt;
      rest_cnt    <= rest_nxt;
      idle        <= (state_nxt == IDLE);
      gamma_start <= (state == IDLE) && (state_nxt == COMPUTE);
      gamma_done  <= (state_nxt == REST) && (rest_nxt == REST_LAST);
      busy        <= (state_nxt != IDLE);
    end
  end

endmodule

// File: rtl/temporal_encoder_16.sv
// Temporal (1->0 transition) encoder feeding the 16-input bitonic sorter.
// Line i falls at the gamma tick equal to its captured value, then all lines
// return high for the rest window.
// Optional macro TNN_NULL_SPIKE_EN: an all-ones value is a null spike and the
// line stays high for the whole compute window.
module temporal_encoder_16
  import tnn_pkg::*;
#(
  parameter int unsigned N        = N_LINES,
  parameter int unsigned TW       = TW_DEF,
  parameter int unsigned REST_CYC = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  temporal_encoder_16_if.slave  in_if,
  output logic [N-1:0]          spike_out,
  output logic                  gamma_start,
  output logic                  gamma_done,
  output logic                  busy
);

  logic            accept;
  logic            ready_q;
  enc_state_t      state_nxt;
  logic [TW:0]     tick_nxt;
  logic [N*TW-1:0] val_q;
  logic [N*TW-1:0] val_d;
  logic [N-1:0]    spike_nxt;
  logic            in_compute;

  assign in_if.in_ready = ready_q;
  assign accept         = in_if.in_valid && ready_q;
  assign in_compute     = (state_nxt == COMPUTE);

  gamma_timer #(
    .TW       (TW),
    .REST_CYC (REST_CYC)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .start       (accept),
    .state_nxt   (state_nxt),
    .tick_nxt    (tick_nxt),
    .idle        (ready_q),
    .gamma_start (gamma_start),
    .gamma_done  (gamma_done),
    .busy        (busy)
  );

  // Level is evaluated against next-cycle tick/value so the registered line
  // already reflects tick 0 in the first COMPUTE cycle.
  for (genvar i = 0; i < N; i++) begin : g_line
    logic [TW-1:0] v;
    logic          fall;

    assign val_d[TW*i +: TW] = accept ? in_if.in_data[TW*i +: TW] : val_q[TW*i +: TW];
    assign v = val_d[TW*i +: TW];
`ifdef TNN_NULL_SPIKE_EN
    assign fall = ({1'b0, v} <= tick_nxt) && (v != '1);
`else
    assign fall = ({1'b0, v} <= tick_nxt);
`endif
    assign spike_nxt[i] = !(in_compute && fall);
  end

  // Captured values and encoded line levels.
  always_ff @(posedge clk) begin
    if (rst) begin
      val_q     <= '0;
      spike_out <= '1;
    end else begin
      val_q     <= val_d;
      spike_out <= spike_nxt;
    end
  end

endmodule

// File: tb/tb_temporal_encoder_16.sv
// Scoreboard bench for temporal_encoder_16: a cycle model pushes expected
// outputs each clock, a monitor pops and compares; directed point checks
// confirm hand-computed waveform landmarks.
module tb_temporal_encoder_16;
  import tnn_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  temporal_encoder_16_if #(.N(16), .TW(3)) bus ();

  logic [15:0] spike_out;
  logic        gamma_start;
  logic        gamma_done;
  logic        busy;

  temporal_encoder_16 #(.N(16), .TW(3), .REST_CYC(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_if       (bus),
    .spike_out   (spike_out),
    .gamma_start (gamma_start),
    .gamma_done  (gamma_done),
    .busy        (busy)
  );

  typedef struct packed {
    logic [15:0] spike;
    logic        ready;
    logic        busy;
    logic        gs;
    logic        gd;
  } obs_t;

  obs_t exp_q[$];
  int   vectors = 0;
  int   errors  = 0;

  // Reference model: phase = cycles since handshake (0 = idle), 1..8 compute, 9..10 rest.
  int          phase = 0;
  spike_time_t mval[16];

  function automatic obs_t model_out();
    obs_t o;
    bit   is_null;
    o.spike = 16'hFFFF;
    o.ready = (phase == 0);
    o.busy  = (phase != 0);
    o.gs    = (phase == 1);
    o.gd    = (phase == 10);
    if (phase >= 1 && phase <= 8) begin
      for (int i = 0; i < 16; i++) begin
`ifdef TNN_NULL_SPIKE_EN
        is_null = (mval[i] == 3'd7);
`else
        is_null = 1'b0;
`endif
        if (int'(mval[i]) <= phase - 1 && !is_null) o.spike[i] = 1'b0;
      end
    end
    return o;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      phase = 0;
    end else if (phase == 0) begin
      if (bus.in_valid === 1'b1) begin
        phase = 1;
        for (int i = 0; i < 16; i++) mval[i] = bus.in_data[3*i +: 3];
      end
    end else if (phase == 10) begin
      phase = 0;
    end else begin
      phase++;
    end
    exp_q.push_back(model_out());
  end

  // Monitor: compare every presented output cycle against the scoreboard.
  initial begin
    forever begin : mon
      obs_t e;
      obs_t a;
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {spike_out, bus.in_ready, busy, gamma_start, gamma_done};
        vectors++;
        if (a !== e) begin
          errors++;
          $display("FAIL cycle t=%0t: got spike=%h rdy=%b busy=%b gs=%b gd=%b, expected spike=%h rdy=%b busy=%b gs=%b gd=%b",
                   $time, a.spike, a.ready, a.busy, a.gs, a.gd, e.spike, e.ready, e.busy, e.gs, e.gd);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", {31'd0, bus.in_ready}, 32'd1);
  endtask

  // Handshake one vector; returns just after the handshake edge (cycle T+1 starts).
  task automatic send(input logic [47:0] d);
    wait_idle();
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #2;
    bus.in_valid = 1'b0;
    bus.in_data  = 48'hA5A5_5A5A_C3C3;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [47:0] d;
    logic [47:0] b;

    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    @(negedge clk);
    check("rst_spike", {16'd0, spike_out}, 32'h0000_FFFF);
    check("rst_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_pulses", {30'd0, gamma_start, gamma_done}, 32'd0);

    // Distinct values: line i = i mod 8.
    for (int i = 0; i < 16; i++) d[3*i +: 3] = 3'(i % 8);
    send(d);
    @(negedge clk);
    check("dist_t1_spike", {16'd0, spike_out}, 32'h0000_FEFE);
    check("dist_t1_gstart", {31'd0, gamma_start}, 32'd1);
    repeat (7) @(negedge clk);
    check("dist_t8_spike", {16'd0, spike_out}, 32'h0000_0000);
    @(negedge clk);
    check("dist_t9_spike", {16'd0, spike_out}, 32'h0000_FFFF);
    @(negedge clk);
    check("dist_t10_gdone", {31'd0, gamma_done}, 32'd1);
    @(negedge clk);
    check("dist_t11_ready", {31'd0, bus.in_ready}, 32'd1);

    // Ties: all lines = 3.
    for (int i = 0; i < 16; i++) d[3*i +: 3] = 3'd3;
    send(d);
    repeat (3) @(negedge clk);
    check("ties_t3_spike", {16'd0, spike_out}, 32'h0000_FFFF);
    @(negedge clk);
    check("ties_t4_spike", {16'd0, spike_out}, 32'h0000_0000);
    repeat (4) @(negedge clk);
    check("ties_t8_spike", {16'd0, spike_out}, 32'h0000_0000);

    // Mid-run reset during cycle T+5.
    for (int i = 0; i < 16; i++) d[3*i +: 3] = 3'(i % 8);
    send(d);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("midrst_spike", {16'd0, spike_out}, 32'h0000_FFFF);
    check("midrst_ready", {31'd0, bus.in_ready}, 32'd1);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("midrst_no_gdone", {31'd0, gamma_done}, 32'd0);
    end

    // Backpressure: second vector held valid during the first gamma cycle.
    for (int i = 0; i < 16; i++) d[3*i +: 3] = 3'((3 * i) % 8);
    for (int i = 0; i < 16; i++) b[3*i +: 3] = 3'(7 - (i % 8));
    wait_idle();
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #2 bus.in_data = b;
    @(negedge clk);
    check("bp_t1_ready", {31'd0, bus.in_ready}, 32'd0);
    repeat (9) @(negedge clk);
    check("bp_t10_ready", {31'd0, bus.in_ready}, 32'd0);
    @(negedge clk);
    check("bp_t11_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #2 bus.in_valid = 1'b0;
    @(negedge clk);
    check("bp_b_gstart", {31'd0, gamma_start}, 32'd1);
    check("bp_b_t1_spike", {16'd0, spike_out}, 32'h0000_7F7F);

    // Null spike: line 5 = 7, all others = 2.
    for (int i = 0; i < 16; i++) d[3*i +: 3] = 3'd2;
    d[15 +: 3] = 3'd7;
    send(d);
    repeat (7) @(negedge clk);
    check("null_t7_spike", {16'd0, spike_out}, 32'h0000_0020);
    @(negedge clk);
`ifdef TNN_NULL_SPIKE_EN
    check("null_t8_spike", {16'd0, spike_out}, 32'h0000_0020);
`else
    check("null_t8_spike", {16'd0, spike_out}, 32'h0000_0000);
`endif

    wait_idle();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
